// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter
//   Round-robin arbiter that merges two AXI-Stream requesters into one
//   registered stream feeding a UART transmitter. A grant is held until the
//   granted requester delivers a beat with tlast, or until MAX_BURST beats
//   have been accepted, whichever comes first. Every grant is followed by at
//   least one idle cycle before the next arbitration.
//
//   State table
//     state  | meaning
//     IDLE   | no grant; arbitrate between pending requesters
//     GRANT0 | requester 0 owns the output stream
//     GRANT1 | requester 1 owns the output stream
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s0_tdata/tvalid/tlast/tready  requester 0 AXI-Stream slave
//   s1_tdata/tvalid/tlast/tready  requester 1 AXI-Stream slave
//   m_tdata/tvalid/tlast/tid      registered master stream, tid = source index
//   m_tready                      downstream ready
//   busy                          high while granted or a beat is still held
module axis_tx_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tid,
  input  logic              m_tready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Count value held just before the beat that reaches the burst cap.
  localparam logic [7:0] CAP_LAST = 8'(MAX_BURST - 1);

  state_t            state;
  logic              rr_ptr;     // index of the requester granted most recently
  logic [7:0]        beat_cnt;

  logic              slot_free;
  logic              acc0;
  logic              acc1;
  logic              acc;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;
  logic              winner;

  // The output register can take a new beat when empty or being drained this
  // cycle; this is the only combinational path from an input to an output.
  assign slot_free = !m_tvalid || m_tready;
  assign s0_tready = (state == GRANT0) && slot_free;
  assign s1_tready = (state == GRANT1) && slot_free;

  assign acc0     = s0_tvalid && s0_tready;
  assign acc1     = s1_tvalid && s1_tready;
  assign acc      = acc0 || acc1;
  assign acc_last = acc1 ? s1_tlast : s0_tlast;
  assign acc_data = acc1 ? s1_tdata : s0_tdata;

  // On a tie the requester not served last wins.
  assign winner = (s0_tvalid && s1_tvalid) ? !rr_ptr : s1_tvalid;

  assign busy = (state != IDLE) || m_tvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b1;
      beat_cnt <= 8'd0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= 1'b0;
    end else begin
      if (acc) begin
        m_tdata  <= acc_data;
        m_tlast  <= acc_last;
        m_tid    <= acc1;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s0_tvalid || s1_tvalid) begin
            state    <= winner ? GRANT1 : GRANT0;
            rr_ptr   <= winner;
            beat_cnt <= 8'd0;
          end
        end
        GRANT0, GRANT1: begin
          if (acc) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (acc_last || (beat_cnt == CAP_LAST)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Testbench for axis_tx_arbiter: directed scenarios plus randomized traffic
// checked against a packet-level arbitration model.
module tb_axis_tx_arbiter;

  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
  logic          s0_tready, s1_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tid;
  logic          m_tready = 1'b0;
  logic          busy;

  axis_tx_arbiter #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid),
    .m_tready(m_tready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; bit l; } beat_t;
  typedef struct { logic [DW-1:0] d; bit l; bit id; } obeat_t;

  beat_t  q0[$];
  beat_t  q1[$];
  obeat_t exp_q[$];
  int     out_tid[$];
  int     out_cyc[$];
  bit     model_ptr = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0;
    s0_tdata = '0; s1_tdata = '0; m_tready = 0;
    q0.delete(); q1.delete(); exp_q.delete();
    model_ptr = 1'b1;
    tick();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic push(input bit src, input logic [DW-1:0] d, input bit l);
    beat_t b;
    b.d = d; b.l = l;
    if (src) q1.push_back(b); else q0.push_back(b);
  endtask

  // Packet-level model: at each arbitration point pick the only pending
  // requester, or on a tie the one not served last; a grant then carries
  // beats until tlast, MAXB beats, or the requester runs dry.
  task automatic build_expected();
    beat_t  a[$];
    beat_t  b[$];
    beat_t  bt;
    obeat_t o;
    bit     w;
    bit     more;
    int     n;
    a = q0; b = q1;
    exp_q.delete();
    while (a.size() != 0 || b.size() != 0) begin
      if (a.size() != 0 && b.size() != 0) w = !model_ptr;
      else w = (b.size() != 0);
      model_ptr = w;
      n = 0;
      more = 1;
      while (more) begin
        if (w) bt = b.pop_front(); else bt = a.pop_front();
        o.d = bt.d; o.l = bt.l; o.id = w;
        exp_q.push_back(o);
        n++;
        if (bt.l || n == MAXB || (w ? b.size() : a.size()) == 0) more = 0;
      end
    end
  endtask

  // Drives both queues with tvalid held whenever beats remain and compares
  // every delivered beat against the model.
  task automatic run_traffic(input bit rnd);
    int            idx0, idx1, budget;
    bit            prev_stall, a0, a1;
    logic [DW-1:0] pd;
    logic          pl, pt;
    obeat_t        e;
    idx0 = 0; idx1 = 0; budget = 0; prev_stall = 0;
    pd = '0; pl = 0; pt = 0;
    build_expected();
    out_tid.delete(); out_cyc.delete();
    while (!(idx0 == q0.size() && idx1 == q1.size() && exp_q.size() == 0) && budget < LIMIT) begin
      s0_tvalid = (idx0 < q0.size());
      s0_tdata  = s0_tvalid ? q0[idx0].d : '0;
      s0_tlast  = s0_tvalid ? q0[idx0].l : 1'b0;
      s1_tvalid = (idx1 < q1.size());
      s1_tdata  = s1_tvalid ? q1[idx1].d : '0;
      s1_tlast  = s1_tvalid ? q1[idx1].l : 1'b0;
      m_tready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(m_tvalid), 32'h1);
        check("hold_data", 32'(m_tdata), 32'(pd));
        check("hold_last", 32'(m_tlast), 32'(pl));
        check("hold_tid", 32'(m_tid), 32'(pt));
      end
      check("ready_excl", 32'(s0_tready && s1_tready), 32'h0);
      if (m_tvalid && m_tready) begin
        check("extra_beat", 32'(exp_q.size() == 0), 32'h0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_tdata), 32'(e.d));
          check("out_last", 32'(m_tlast), 32'(e.l));
          check("out_tid", 32'(m_tid), 32'(e.id));
        end
        out_tid.push_back(int'(m_tid));
        out_cyc.push_back(cyc);
      end
      a0 = s0_tvalid && s0_tready;
      a1 = s1_tvalid && s1_tready;
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pl = m_tlast; pt = m_tid;
      tick();
      if (a0) idx0++;
      if (a1) idx1++;
      budget++;
    end
    check("traffic_timeout", 32'(budget >= LIMIT), 32'h0);
    s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0;
  endtask

  int exp_burst_tid[13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
  int exp_tie_tid[6]    = '{0, 0, 1, 1, 0, 0};

  initial begin
    // Reset state
    do_reset();
    m_tready = 1;
    #1;
    check("rst_mvalid", 32'(m_tvalid), 32'h0);
    check("rst_mdata", 32'(m_tdata), 32'h0);
    check("rst_mlast", 32'(m_tlast), 32'h0);
    check("rst_mtid", 32'(m_tid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_s0_ready", 32'(s0_tready), 32'h0);
    check("rst_s1_ready", 32'(s1_tready), 32'h0);

    // Single source, three beats, full throughput
    tick();
    s0_tvalid = 1; s0_tdata = 8'h41; s0_tlast = 0; m_tready = 1;
    tick();
    check("single_no_early_valid", 32'(m_tvalid), 32'h0);
    check("single_s0_ready", 32'(s0_tready), 32'h1);
    check("single_s1_ready", 32'(s1_tready), 32'h0);
    tick();
    check("single_valid_lat2", 32'(m_tvalid), 32'h1);
    check("single_data0", 32'(m_tdata), 32'h41);
    check("single_tid0", 32'(m_tid), 32'h0);
    s0_tdata = 8'h42;
    tick();
    check("single_data1", 32'(m_tdata), 32'h42);
    s0_tdata = 8'h43; s0_tlast = 1;
    tick();
    check("single_data2", 32'(m_tdata), 32'h43);
    check("single_last", 32'(m_tlast), 32'h1);
    s0_tvalid = 0; s0_tlast = 0;
    check("single_idle_ready", 32'(s0_tready), 32'h0);
    check("single_busy_held", 32'(busy), 32'h1);
    tick();
    check("single_drained", 32'(m_tvalid), 32'h0);
    check("single_busy_clear", 32'(busy), 32'h0);

    // Tie from reset, then a second tie while both still pending
    do_reset();
    push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    run_traffic(0);
    check("tie_count", 32'(out_tid.size()), 32'd6);
    foreach (exp_tie_tid[i]) check($sformatf("tie_tid%0d", i), 32'(out_tid[i]), 32'(exp_tie_tid[i]));
    check("tie_back2back", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
    check("tie_bubble1", 32'(out_cyc[2] - out_cyc[1]), 32'd2);
    check("tie_bubble2", 32'(out_cyc[4] - out_cyc[3]), 32'd2);

    // Backpressure: beat 0x55 held for five cycles
    do_reset();
    s0_tvalid = 1; s0_tdata = 8'h55; s0_tlast = 0; m_tready = 0;
    tick();
    check("bp_grant_ready", 32'(s0_tready), 32'h1);
    tick();
    s0_tdata = 8'h56; s0_tlast = 1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(m_tvalid), 32'h1);
      check("bp_data", 32'(m_tdata), 32'h55);
      check("bp_s0_ready", 32'(s0_tready), 32'h0);
      tick();
    end
    m_tready = 1;
    #1;
    check("bp_release_ready", 32'(s0_tready), 32'h1);
    check("bp_release_data", 32'(m_tdata), 32'h55);
    tick();
    check("bp_next_data", 32'(m_tdata), 32'h56);
    check("bp_next_last", 32'(m_tlast), 32'h1);
    check("bp_next_valid", 32'(m_tvalid), 32'h1);
    s0_tvalid = 0; s0_tlast = 0;
    tick();
    check("bp_no_dup", 32'(m_tvalid), 32'h0);

    // Burst cap: s1 streams without tlast while s0 has single-beat packets
    do_reset();
    for (int i = 0; i < 3; i++) push(0, 8'(8'hC0 + i), 1);
    for (int i = 0; i < 10; i++) push(1, 8'(8'hD0 + i), 0);
    run_traffic(0);
    check("burst_count", 32'(out_tid.size()), 32'd13);
    foreach (exp_burst_tid[i]) check($sformatf("burst_tid%0d", i), 32'(out_tid[i]), 32'(exp_burst_tid[i]));
    // s1 went quiet mid-grant without tlast: grant must persist
    s0_tvalid = 1; s0_tdata = 8'hEE; s0_tlast = 1; m_tready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_grant_s0_ready", 32'(s0_tready), 32'h0);
      check("hold_grant_s1_ready", 32'(s1_tready), 32'h1);
      check("hold_grant_busy", 32'(busy), 32'h1);
      tick();
    end

    // Reset in the middle of a packet with a beat held
    do_reset();
    s0_tvalid = 1; s0_tdata = 8'h10; s0_tlast = 0; m_tready = 1;
    tick();
    tick();
    s0_tdata = 8'h11;
    tick();
    check("mid_held_before", 32'(m_tdata), 32'h11);
    s0_tdata = 8'h12; m_tready = 0;
    tick();
    check("mid_held_stall", 32'(m_tdata), 32'h11);
    rst = 1;
    #1;
    check("mid_rst_valid", 32'(m_tvalid), 32'h0);
    check("mid_rst_data", 32'(m_tdata), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(s0_tready), 32'h0);
    rst = 0;
    m_tready = 1;
    tick();
    check("mid_no_beat_at_grant", 32'(m_tvalid), 32'h0);
    check("mid_regrant_ready", 32'(s0_tready), 32'h1);
    tick();
    check("mid_new_valid", 32'(m_tvalid), 32'h1);
    check("mid_new_data", 32'(m_tdata), 32'h12);
    s0_tdata = 8'h13; s0_tlast = 1;
    tick();
    s0_tvalid = 0; s0_tlast = 0;
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int r = 0; r < 4; r++) begin
      q0.delete(); q1.delete();
      for (int s = 0; s < 2; s++) begin
        int n;
        n = $urandom_range(3, 14);
        for (int i = 0; i < n; i++)
          push(s[0], 8'($urandom), (i == n - 1) || ($urandom_range(0, 3) == 0));
      end
      run_traffic(1);
      check("rand_model_drained", 32'(exp_q.size()), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
